palette_color_encoder: RTL and testbench
========================================

Name: palette_color_encoder

Overview:
- Inverse of the sprite palette lookup: takes a 12-bit RGB pixel and returns the 4-bit palette index of the closest palette colour, plus its distance.
- Used by the sprite-capture/recolour path to re-quantise processed pixels back into index form before they are written to sprite ROM/RAM images.
- Sequential search, one palette entry per clock, with valid/ready handshakes on input and output.

Parameters:
- NUM_ENTRIES, 16, palette size; fixed at 16 in this revision (index width 4).
- CHROMA_KEY_EN, 1, when 1 entry 0 (transparent key F0F) matches only on exact equality and is excluded from the nearest-colour search.

Ports:
- Clk  input  1  system clock
- Reset_n  input  1  asynchronous active-low reset
- in_valid  input  1  pixel presented
- in_ready  output  1  block can accept a pixel
- in_red  input  4  pixel red
- in_green  input  4  pixel green
- in_blue  input  4  pixel blue
- out_valid  output  1  result available
- out_ready  input  1  consumer takes result
- out_index  output  4  chosen palette index
- out_dist  output  6  Manhattan distance to chosen entry (0..45)

Behaviour:
- Reset (asynchronous, Reset_n=0): state IDLE, out_valid=0, out_index=0, out_dist=0, best registers cleared. in_ready=1 whenever the state is IDLE, including during reset.
- Palette contents, index 0..15: F0F,531,C1C,373,A56,121,614,411,C96,817,151,E1E,7A5,823,D69,A19.
- Distance: |dr|+|dg|+|db| on 4-bit channels, zero-extended to 6 bits. No overflow is possible.
- States: IDLE, SEARCH, DONE.
- IDLE: in_ready=1. The pixel is accepted on a clock edge where in_valid=1 and in_ready=1, and is latched.
  - If CHROMA_KEY_EN=1 and the pixel is F0F, go to DONE with index 0, dist 0.
  - Otherwise go to SEARCH with ptr=1, best_dist=63, best_idx=0.
  - With CHROMA_KEY_EN=0, ptr starts at 0 and entry 0 is searched like any other entry.
- SEARCH: in_ready=0. Each edge evaluates entry ptr.
  - best is updated only on strictly smaller distance, so ties resolve to the lowest index.
  - On dist==0 (early exit) or ptr==15, go to DONE and write best to out_index/out_dist.
  - Otherwise increment ptr.
- DONE: out_valid=1. out_index/out_dist are held stable while out_ready=0. On the edge with out_ready=1, go to IDLE and clear out_valid.
- Latency, counted from the acceptance edge to out_valid high:
  - chroma key: out_valid is high in the cycle immediately after the acceptance edge (0 extra edges).
  - exact hit at entry k: k edges after acceptance.
  - no exact hit: 15 edges.
- No pipelining: a new pixel is accepted no earlier than the edge after the output is consumed.
- in_* values are ignored while in_ready=0.
- Reset during SEARCH or DONE aborts immediately. No result is emitted and the block is in IDLE after reset release.
- in_valid is sampled only in IDLE. An in_valid held high across DONE is accepted on the first IDLE edge.

Decomposition:
- Package palette_pkg:
  - rgb12_t (packed 4/4/4)
  - PALETTE constant of 16 rgb12_t, shared with the palette lookup so both directions use one table
  - DIST_W=6
  - CHROMA_KEY=12'hF0F
  - state enum
- Sub-module color_dist: combinational, two rgb12_t in, 6-bit Manhattan distance out; instantiated once.

Test Plan:
- Reset, then pixel 531 -> index 1, dist 0, out_valid 1 edge after acceptance (early exit).
- Pixel 000 -> index 5, dist 4, out_valid 15 edges after acceptance.
- Pixel D1D (equidistant from C1C and E1E) -> index 2, dist 2 (lowest-index tie rule).
- Pixel F0F -> index 0, dist 0, out_valid in the cycle after acceptance.
- Pixel F0E (distance 1 from the key) -> index 11, dist 2; entry 0 excluded.
- Backpressure and reset:
  - Hold out_ready=0 for 5 cycles on pixel 000 -> out_index/out_dist stay 5/4 and in_ready stays 0.
  - Then pulse Reset_n low mid-search on a second pixel -> out_valid 0, IDLE, in_ready 1, no spurious result.

Source files
------------

// File: rtl/palette_pkg.sv
// Shared palette definitions: the 16-entry sprite palette used by both the
// index->RGB lookup and the RGB->index encoder, plus encoder FSM types.
package palette_pkg;

  localparam int PAL_ENTRIES = 16;
  localparam int IDX_W       = 4;
  localparam int DIST_W      = 6;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb12_t;

  localparam rgb12_t CHROMA_KEY = 12'hF0F;

  localparam rgb12_t PALETTE [PAL_ENTRIES] = '{
    12'hF0F, 12'h531, 12'hC1C, 12'h373, 12'hA56, 12'h121, 12'h614, 12'h411,
    12'hC96, 12'h817, 12'h151, 12'hE1E, 12'h7A5, 12'h823, 12'hD69, 12'hA19
  };

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/color_dist.sv
// Manhattan distance between two 12-bit RGB colours (max 3*15 = 45).
module color_dist
  import palette_pkg::*;
(
  input  rgb12_t            a_i,
  input  rgb12_t            b_i,
  output logic [DIST_W-1:0] dist_o
);

  logic [3:0] dr, dg, db;

  always_comb begin
    dr     = (a_i.r > b_i.r) ? (a_i.r - b_i.r) : (b_i.r - a_i.r);
    dg     = (a_i.g > b_i.g) ? (a_i.g - b_i.g) : (b_i.g - a_i.g);
    db     = (a_i.b > b_i.b) ? (a_i.b - b_i.b) : (b_i.b - a_i.b);
    dist_o = DIST_W'(dr) + DIST_W'(dg) + DIST_W'(db);
  end

endmodule

// File: rtl/palette_color_encoder.sv
// Re-quantises a 12-bit RGB pixel to the nearest palette index, scanning one
// palette entry per clock. Handshakes: a transfer happens on a rising edge
// where valid and ready are both 1; the producer holds data while valid=1.
module palette_color_encoder
  import palette_pkg::*;
#(
  parameter int NUM_ENTRIES   = 16,
  parameter bit CHROMA_KEY_EN = 1'b1
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_red,
  input  logic [3:0]        in_green,
  input  logic [3:0]        in_blue,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IDX_W-1:0]  out_index,
  output logic [DIST_W-1:0] out_dist,
  output state_t            dbg_state_o
);

  localparam logic [IDX_W-1:0] LAST_PTR  = IDX_W'(NUM_ENTRIES - 1);
  localparam logic [IDX_W-1:0] FIRST_PTR = CHROMA_KEY_EN ? IDX_W'(1) : IDX_W'(0);

  state_t             state_q, state_d;
  rgb12_t             pix_q, pix_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   best_idx_q, best_idx_d;
  logic [DIST_W-1:0]  best_dist_q, best_dist_d;
  logic [IDX_W-1:0]   out_index_q, out_index_d;
  logic [DIST_W-1:0]  out_dist_q, out_dist_d;

  rgb12_t             in_pix;
  logic [DIST_W-1:0]  cur_dist;
  logic [IDX_W-1:0]   cand_idx;
  logic [DIST_W-1:0]  cand_dist;

  assign in_pix = '{r: in_red, g: in_green, b: in_blue};

  color_dist u_color_dist (
    .a_i    (pix_q),
    .b_i    (PALETTE[ptr_q]),
    .dist_o (cur_dist)
  );

  // Strict less-than keeps the earlier (lower) index on ties.
  always_comb begin
    cand_idx  = best_idx_q;
    cand_dist = best_dist_q;
    if (cur_dist < best_dist_q) begin
      cand_idx  = ptr_q;
      cand_dist = cur_dist;
    end
  end

  always_comb begin
    state_d     = state_q;
    pix_d       = pix_q;
    ptr_d       = ptr_q;
    best_idx_d  = best_idx_q;
    best_dist_d = best_dist_q;
    out_index_d = out_index_q;
    out_dist_d  = out_dist_q;
    in_ready    = 1'b0;
    out_valid   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          pix_d = in_pix;
          if (CHROMA_KEY_EN && (in_pix == CHROMA_KEY)) begin
            state_d     = ST_DONE;
            out_index_d = '0;
            out_dist_d  = '0;
          end else begin
            state_d     = ST_SEARCH;
            ptr_d       = FIRST_PTR;
            best_idx_d  = '0;
            best_dist_d = '1;
          end
        end
      end
      ST_SEARCH: begin
        best_idx_d  = cand_idx;
        best_dist_d = cand_dist;
        if ((cur_dist == '0) || (ptr_q == LAST_PTR)) begin
          state_d     = ST_DONE;
          out_index_d = cand_idx;
          out_dist_d  = cand_dist;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= ST_IDLE;
      pix_q       <= '0;
      ptr_q       <= '0;
      best_idx_q  <= '0;
      best_dist_q <= '0;
      out_index_q <= '0;
      out_dist_q  <= '0;
    end else begin
      state_q     <= state_d;
      pix_q       <= pix_d;
      ptr_q       <= ptr_d;
      best_idx_q  <= best_idx_d;
      best_dist_q <= best_dist_d;
      out_index_q <= out_index_d;
      out_dist_q  <= out_dist_d;
    end
  end

  assign out_index   = out_index_q;
  assign out_dist    = out_dist_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_palette_color_encoder.sv
// Directed bench for palette_color_encoder: nearest-colour results, latency,
// chroma key, backpressure hold and asynchronous reset abort.
module tb_palette_color_encoder;
  import palette_pkg::*;

  logic        Clk;
  logic        Reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_red, in_green, in_blue;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_index;
  logic [5:0]  out_dist;
  state_t      dbg_state;

  int total = 0;
  int bad   = 0;

  palette_color_encoder #(
    .NUM_ENTRIES   (16),
    .CHROMA_KEY_EN (1'b1)
  ) dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_red      (in_red),
    .in_green    (in_green),
    .in_blue     (in_blue),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_index   (out_index),
    .out_dist    (out_dist),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Present one pixel, wait for the result and check index/dist/latency.
  // Returns with the result still pending (out_ready left at 0).
  task automatic run_pixel(input logic [11:0] px, input int exp_idx,
                           input int exp_dist, input int exp_lat, input string tag);
    int lat;
    logic seen;
    @(negedge Clk);
    {in_red, in_green, in_blue} = px;
    in_valid = 1'b1;
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    @(posedge Clk);
    #1;
    in_valid = 1'b0;
    {in_red, in_green, in_blue} = 12'(px ^ 12'hFFF);
    lat  = 0;
    seen = out_valid;
    while (!seen && lat < 40) begin
      @(posedge Clk);
      #1;
      lat++;
      seen = out_valid;
    end
    check({tag, "_valid"},   32'(seen),      32'd1);
    check({tag, "_latency"}, 32'(lat),       32'(exp_lat));
    check({tag, "_index"},   32'(out_index), 32'(exp_idx));
    check({tag, "_dist"},    32'(out_dist),  32'(exp_dist));
  endtask

  task automatic consume(input string tag);
    @(negedge Clk);
    out_ready = 1'b1;
    @(posedge Clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_valid_clr"}, 32'(out_valid), 32'd0);
    check({tag, "_ready_back"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic spurious;
    Reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    {in_red, in_green, in_blue} = 12'h000;

    // reset state
    #12;
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_index", 32'(out_index), 32'd0);
    check("rst_out_dist",  32'(out_dist),  32'd0);
    check("rst_state",     32'(dbg_state), 32'(ST_IDLE));
    @(negedge Clk);
    Reset_n = 1'b1;
    repeat (2) @(negedge Clk);

    // exact hit at entry 1 -> early exit after one edge
    run_pixel(12'h531, 1, 0, 1, "hit531");
    consume("hit531");

    // no exact hit -> full scan, nearest is 121
    run_pixel(12'h000, 5, 4, 15, "px000");
    consume("px000");

    // equidistant from C1C and E1E -> lower index wins
    run_pixel(12'hD1D, 2, 2, 15, "tieD1D");
    consume("tieD1D");

    // chroma key -> result in the cycle after acceptance
    run_pixel(12'hF0F, 0, 0, 0, "keyF0F");
    consume("keyF0F");

    // near the key, but entry 0 excluded from the search
    run_pixel(12'hF0E, 11, 2, 15, "nearkey");
    consume("nearkey");

    // backpressure: result held stable, no new input accepted
    run_pixel(12'h000, 5, 4, 15, "bp");
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      in_valid = 1'b1;
      {in_red, in_green, in_blue} = 12'(12'h531 + i);
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_hold_index", 32'(out_index), 32'd5);
      check("bp_hold_dist",  32'(out_dist),  32'd4);
      check("bp_in_ready",   32'(in_ready),  32'd0);
    end
    @(negedge Clk);
    in_valid = 1'b0;
    consume("bp");

    // reset mid-search aborts without producing a result
    @(negedge Clk);
    {in_red, in_green, in_blue} = 12'h000;
    in_valid = 1'b1;
    @(posedge Clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    check("abort_in_search", 32'(dbg_state), 32'(ST_SEARCH));
    Reset_n = 1'b0;
    #1;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_in_ready",  32'(in_ready),  32'd1);
    check("abort_state",     32'(dbg_state), 32'(ST_IDLE));
    @(negedge Clk);
    Reset_n  = 1'b1;
    spurious = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      if (out_valid) spurious = 1'b1;
    end
    check("abort_no_result", 32'(spurious), 32'd0);
    check("abort_idle",      32'(dbg_state), 32'(ST_IDLE));

    // block is usable again after the abort
    run_pixel(12'hA19, 15, 0, 15, "postrst");
    consume("postrst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
